bits2ascii_tx: RTL



---
 rtl/bits2ascii_pkg.sv | 30 +++
 rtl/bits2ascii_split.sv | 59 +++++
 rtl/bits2ascii_tx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/bits2ascii_pkg.sv
// rtl/bits2ascii_pkg.sv - shared states and constants for bits2ascii_tx (CR/LF states under BITS2ASCII_CRLF_EN)
package bits2ascii_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CONV_H,
        CONV_T,
        SEND_H,
        WAIT_H,
        SEND_T,
        WAIT_T,
        SEND_O,
        WAIT_O
`ifdef BITS2ASCII_CRLF_EN
        ,
        SEND_CR,
        WAIT_CR,
        SEND_LF,
        WAIT_LF
`endif
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'd48;
    localparam logic [7:0] ASCII_CR   = 8'd13;
    localparam logic [7:0] ASCII_LF   = 8'd10;

    localparam logic [7:0] HUNDRED = 8'd100;
    localparam logic [7:0] TEN     = 8'd10;

endpackage

// File: rtl/bits2ascii_split.sv
// rtl/bits2ascii_split.sv - bin2dec_split: repeated-subtraction split of an 8-bit value into h/t/o digits
module bin2dec_split
    import bits2ascii_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] in,
    output logic [1:0] h,
    output logic [3:0] t,
    output logic [7:0] o,
    output logic       valid
);

    state_t     phase;
    logic [7:0] rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= IDLE;
            rem   <= '0;
            h     <= '0;
            t     <= '0;
        end else begin
            case (phase)
                IDLE: begin
                    if (start) begin
                        rem   <= in;
                        h     <= '0;
                        t     <= '0;
                        phase <= CONV_H;
                    end
                end
                CONV_H: begin
                    if (rem >= HUNDRED) begin
                        rem <= rem - HUNDRED;
                        h   <= h + 2'd1;
                    end else begin
                        phase <= CONV_T;
                    end
                end
                CONV_T: begin
                    if (rem >= TEN) begin
                        rem <= rem - TEN;
                        t   <= t + 4'd1;
                    end else begin
                        phase <= IDLE;
                    end
                end
                default: phase <= IDLE;
            endcase
        end
    end

    // Digits are final during the last CONV_T cycle and held until the next start.
    assign o     = rem;
    assign valid = (phase == CONV_T) && (rem < TEN);

endmodule

// File: rtl/bits2ascii_tx.sv
// rtl/bits2ascii_tx.sv - sends an 8-bit value as 3 ASCII digits to UART TX; BITS2ASCII_CRLF_EN appends CR LF
module bits2ascii_tx
    import bits2ascii_pkg::*;
#(
    parameter logic [7:0] ZERO_CHAR = ASCII_ZERO
`ifdef BITS2ASCII_CRLF_EN
    ,
    parameter logic [7:0] CR_CHAR   = ASCII_CR,
    parameter logic [7:0] LF_CHAR   = ASCII_LF
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    input  logic       start,
    input  logic       tx_done,
    output logic [7:0] tx_byte,
    output logic       tx_dv,
    output logic       busy,
    output logic       done
);

    state_t     state;
    logic [1:0] h;
    logic [3:0] t;
    logic [7:0] o;
    logic       valid;
    logic       split_start;
    logic       ack;

    assign split_start = start && (state == IDLE);
    // A tx_done coinciding with our own load strobe belongs to an earlier byte.
    assign ack         = tx_done && !tx_dv;

    bin2dec_split u_split (
        .clk   (clk),
        .rst   (rst),
        .start (split_start),
        .in    (in),
        .h     (h),
        .t     (t),
        .o     (o),
        .valid (valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx_byte <= '0;
            tx_dv   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            tx_dv <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CONV_H;
                        busy  <= 1'b1;
                    end
                end
                CONV_H: begin
                    if (valid) state <= SEND_H;
                end
                SEND_H: begin
                    tx_dv   <= 1'b1;
                    tx_byte <= ZERO_CHAR + {6'd0, h};
                    state   <= WAIT_H;
                end
                WAIT_H: begin
                    if (ack) state <= SEND_T;
                end
                SEND_T: begin
                    tx_dv   <= 1'b1;
                    tx_byte <= ZERO_CHAR + {4'd0, t};
                    state   <= WAIT_T;
                end
                WAIT_T: begin
                    if (ack) state <= SEND_O;
                end
                SEND_O: begin
                    tx_dv   <= 1'b1;
                    tx_byte <= ZERO_CHAR + o;
                    state   <= WAIT_O;
                end
`ifdef BITS2ASCII_CRLF_EN
                WAIT_O: begin
                    if (ack) state <= SEND_CR;
                end
                SEND_CR: begin
                    tx_dv   <= 1'b1;
                    tx_byte <= CR_CHAR;
                    state   <= WAIT_CR;
                end
                WAIT_CR: begin
                    if (ack) state <= SEND_LF;
                end
                SEND_LF: begin
                    tx_dv   <= 1'b1;
                    tx_byte <= LF_CHAR;
                    state   <= WAIT_LF;
                end
                WAIT_LF: begin
                    if (ack) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
`else
                WAIT_O: begin
                    if (ack) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
